// File: rtl/fetch_unit_if.sv
// Instruction-memory request/grant/response bus.
// fetch_unit drives the master side; the memory model or arbiter drives the slave side.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: program counter, one-deep imem fetch tracking, 2-entry {pc, instr} queue.
// Optional macro FETCH_MISALIGN_TRAP_EN adds fetch_fault for misaligned redirect targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    fetch_unit_if.master imem,
    output logic [31:0]  pc_out,
    output logic [31:0]  instr_out,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic         fetch_fault,
`endif
    output logic         valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] tag_q, tag_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_pc_d    [2];
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_instr_d [2];

    logic        resp;
    logic        push;
    logic        pop;
    logic        grant;
    logic        blocked;
    logic        wr_idx;
    logic [2:0]  room;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;

    assign blocked     = fault_q;
    assign fetch_fault = fault_q;

    // A redirect decides the fault state: misaligned target sets it, aligned target clears it.
    always_comb begin
        fault_d = fault_q;
        if (redirect) begin
            fault_d = |redirect_pc[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
`else
    logic        unused_redirect_lsbs;

    assign blocked              = 1'b0;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

    assign valid     = (count_q != 2'd0);
    assign pc_out    = fifo_pc_q[rd_ptr_q];
    assign instr_out = fifo_instr_q[rd_ptr_q];
    assign imem.addr = pc_q;

    // Room includes this cycle's pop, so a single-cycle memory streams one word per cycle
    // while a granted fetch is still guaranteed a free slot when its response returns.
    always_comb begin
        resp     = imem.rvalid && outstanding_q;
        pop      = valid && !hold;
        push     = resp && !discard_q && !redirect;
        room     = 3'd2 - {1'b0, count_q} + {2'b00, pop};
        imem.req = !redirect && !rst && !blocked
                   && (!outstanding_q || imem.rvalid)
                   && (room > {2'b00, outstanding_q});
        grant    = imem.req && imem.gnt;
        wr_idx   = rd_ptr_q ^ count_q[0];
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        pc_d          = pc_q;
        tag_d         = tag_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;

        if (grant) begin
            pc_d          = pc_q + 32'd4;
            tag_d         = pc_q;
            outstanding_d = 1'b1;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (resp && discard_q) begin
            discard_d = 1'b0;
        end

        if (push) begin
            fifo_pc_d[wr_idx]    = tag_q;
            fifo_instr_d[wr_idx] = imem.rdata;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        // Redirect beats push/pop; a fetch still in flight belongs to the old stream and is dropped.
        if (redirect) begin
            count_d   = 2'd0;
            pc_d      = {redirect_pc[31:2], 2'b00};
            discard_d = outstanding_q && !imem.rvalid;
        end
    end

    // NOTE: the queue storage is reset as well so pc_out/instr_out read 0, not X, out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            tag_q         <= 32'd0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            fifo_pc_q     <= '{32'd0, 32'd0};
            fifo_instr_q  <= '{32'd0, 32'd0};
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            pc_q          <= pc_d;
            tag_q         <= tag_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_pc_q     <= fifo_pc_d;
            fifo_instr_q  <= fifo_instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic, with a
// stream-level reference model (consumed instructions form consecutive PCs from the last restart).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          consumed = 0;
    logic [31:0] key      = 32'd0;
    int          k_min    = 1;
    int          k_max    = 1;
    bit          gnt_off  = 1'b0;
    bit          gnt_rand = 1'b0;
    txn_t        pend[$];

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
`ifdef FETCH_MISALIGN_TRAP_EN
        .fetch_fault (fetch_fault),
`endif
        .valid       (valid)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ key;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (valid) begin
                seen = 1'b1;
                break;
            end
            adv();
            smp();
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Leaves the bench sampled in the first cycle with rst low.
    task automatic do_reset(input logic [31:0] new_key);
        adv();
        rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        smp();
        check("rst_req", 32'(imem.req), 32'd0);
        adv();
        key = new_key;
        smp();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr_out", instr_out, 32'd0);
        adv();
        rst = 1'b0;
        smp();
        check("first_req", 32'(imem.req), 32'd1);
        check("first_addr", imem.addr, RESET_PC);
        check("first_valid", 32'(valid), 32'd0);
    endtask

    // Memory: in-order responses k_min..k_max cycles after grant, word = addr ^ key.
    initial begin : memory
        txn_t t;
        imem.gnt    = 1'b1;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend.delete();
            end else if (imem.req && imem.gnt) begin
                t.addr = imem.addr;
                t.due  = cyc + int'($urandom_range(k_max, k_min));
                pend.push_back(t);
            end
            @(posedge clk);
            #2;
            imem.rvalid = 1'b0;
            imem.rdata  = $urandom;
            if (pend.size() > 0 && cyc >= pend[0].due) begin
                imem.rvalid = 1'b1;
                imem.rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
            imem.gnt = gnt_off ? 1'b0 : (gnt_rand ? ($urandom_range(2, 0) != 0) : 1'b1);
        end
    end

    // Reference model: every consumed head continues the current stream by +4.
    initial begin : monitor
        logic [31:0] exp_pc;
        logic [31:0] prev_addr;
        bit          prev_stall;
        exp_pc     = RESET_PC;
        prev_addr  = 32'd0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc     = RESET_PC;
                prev_stall = 1'b0;
            end else begin
                if (valid && !hold) begin
                    check("stream_pc", pc_out, exp_pc);
                    check("stream_instr", instr_out, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
                if (imem.req) check("addr_align", {30'd0, imem.addr[1:0]}, 32'd0);
                if (prev_stall && imem.req) check("addr_stable", imem.addr, prev_addr);
                prev_stall = imem.req && !imem.gnt;
                prev_addr  = imem.addr;
                if (redirect) exp_pc = {redirect_pc[31:2], 2'b00};
            end
        end
    end

    initial begin : main
        bit found;
        int start;
        rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

        // Reset release, k=1, word = addr, streaming then a 5-cycle hold.
        do_reset(32'd0);
        adv(); smp();
        check("c2_req", 32'(imem.req), 32'd1);
        check("c2_addr", imem.addr, 32'h4);
        check("c2_valid", 32'(valid), 32'd0);
        adv(); smp();
        check("c3_valid", 32'(valid), 32'd1);
        check("c3_pc", pc_out, 32'h0);
        check("c3_instr", instr_out, 32'h0);
        adv(); hold = 1'b1; smp();
        check("hold_pc", pc_out, 32'h4);
        check("hold_instr", instr_out, 32'h4);
        check("hold_req", 32'(imem.req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            adv(); smp();
            check("hold_pc", pc_out, 32'h4);
            check("hold_req", 32'(imem.req), 32'd0);
        end
        adv(); hold = 1'b0; smp();
        check("release_pc0", pc_out, 32'h4);
        check("release_req", 32'(imem.req), 32'd1);
        check("release_addr", imem.addr, 32'hC);
        adv(); smp();
        check("release_pc1", pc_out, 32'h8);
        adv(); smp();
        check("release_pc2", pc_out, 32'hC);
        for (int i = 0; i < 8; i++) begin
            adv(); smp();
            check("tput_valid", 32'(valid), 32'd1);
            check("tput_pc", pc_out, 32'h10 + 32'(4 * i));
        end

        // Grant withheld for three cycles while 0x8 is requested.
        do_reset(32'd0);
        adv(); smp();
        adv(); gnt_off = 1'b1; smp();
        check("nognt_req", 32'(imem.req), 32'd1);
        check("nognt_addr", imem.addr, 32'h8);
        for (int i = 0; i < 2; i++) begin
            adv(); smp();
            check("nognt_req", 32'(imem.req), 32'd1);
            check("nognt_addr", imem.addr, 32'h8);
        end
        adv(); gnt_off = 1'b0; smp();
        check("gnt_addr", imem.addr, 32'h8);
        adv(); smp();
        check("after_gnt_addr", imem.addr, 32'hC);
        adv(); smp();
        check("after_gnt_valid", 32'(valid), 32'd1);
        check("after_gnt_pc", pc_out, 32'h8);

        // Redirect while the 0x10 fetch is in flight, k=3.
        k_min = 3; k_max = 3;
        do_reset(32'd0);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            if (imem.req && imem.gnt && imem.addr == 32'h10) found = 1'b1;
            else begin
                adv(); smp();
            end
        end
        check("inflight_grant_seen", 32'(found), 32'd1);
        adv(); redirect = 1'b1; redirect_pc = 32'h100; smp();
        check("redir_req_blocked", 32'(imem.req), 32'd0);
        adv(); redirect = 1'b0; smp();
        check("redir_valid", 32'(valid), 32'd0);
        check("redir_addr", imem.addr, 32'h100);
        wait_valid("redir_wait", 40);
        check("redir_first_pc", pc_out, 32'h100);
        check("redir_first_instr", instr_out, 32'h100);

        // Redirect in the same cycle as a response and a pop, k=1.
        k_min = 1; k_max = 1;
        do_reset(32'd0);
        adv(); smp();
        adv(); smp();
        adv(); smp();
        adv(); redirect = 1'b1; redirect_pc = 32'h100; smp();
        check("same_cyc_valid", 32'(valid), 32'd1);
        adv(); redirect = 1'b0; smp();
        check("same_cyc_empty", 32'(valid), 32'd0);
        check("same_cyc_req", 32'(imem.req), 32'd1);
        check("same_cyc_addr", imem.addr, 32'h100);
        adv(); smp();
        check("same_cyc_req2", 32'(imem.req), 32'd1);
        check("same_cyc_addr2", imem.addr, 32'h104);
        adv(); smp();
        check("same_cyc_deliver_valid", 32'(valid), 32'd1);
        check("same_cyc_deliver_pc", pc_out, 32'h100);

        // Misaligned redirect target.
        adv(); redirect = 1'b1; redirect_pc = 32'h102; smp();
        adv(); redirect = 1'b0; smp();
`ifdef FETCH_MISALIGN_TRAP_EN
        check("fault_set", 32'(fetch_fault), 32'd1);
        check("fault_valid", 32'(valid), 32'd0);
        check("fault_req", 32'(imem.req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            adv(); smp();
            check("fault_req", 32'(imem.req), 32'd0);
            check("fault_hold", 32'(fetch_fault), 32'd1);
        end
        adv(); redirect = 1'b1; redirect_pc = 32'h200; smp();
        adv(); redirect = 1'b0; smp();
        check("fault_clear", 32'(fetch_fault), 32'd0);
        check("fault_resume_req", 32'(imem.req), 32'd1);
        check("fault_resume_addr", imem.addr, 32'h200);
        wait_valid("fault_resume_wait", 20);
        check("fault_resume_pc", pc_out, 32'h200);
`else
        check("misalign_valid", 32'(valid), 32'd0);
        check("misalign_req", 32'(imem.req), 32'd1);
        check("misalign_addr", imem.addr, 32'h100);
        wait_valid("misalign_wait", 20);
        check("misalign_pc", pc_out, 32'h100);
`endif

        // PC wrap from 0xFFFF_FFFC to 0.
        adv(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; smp();
        adv(); redirect = 1'b0; smp();
        wait_valid("wrap_wait", 20);
        check("wrap_pc0", pc_out, 32'hFFFF_FFF8);
        adv(); smp();
        check("wrap_pc1", pc_out, 32'hFFFF_FFFC);
        adv(); smp();
        check("wrap_pc2", pc_out, 32'h0);

        // Randomized hold, grant, latency and redirects; each epoch starts with a mid-stream reset.
        for (int epoch = 0; epoch < 4; epoch++) begin
            k_min    = 1;
            k_max    = 1 + (epoch % 3);
            gnt_rand = 1'b1;
            do_reset($urandom);
            start = consumed;
            for (int i = 0; i < 400; i++) begin
                adv();
                hold = ($urandom_range(3, 0) == 0);
                if ($urandom_range(49, 0) == 0) begin
                    redirect    = 1'b1;
                    redirect_pc = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0
                                                              : ($urandom & 32'hFFFF_FFFC);
                end else begin
                    redirect = 1'b0;
                end
                smp();
            end
            adv(); hold = 1'b0; redirect = 1'b0; smp();
            check("random_progress", 32'(consumed > start), 32'd1);
        end
        gnt_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end: owns the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned words in a 2-entry queue. Drives `pc_out`/`instr_out`/`valid` straight into the IF/ID fetch latch, and obeys the same `hold` stall that latch uses. Handles branch/jump redirects by flushing queued and in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `hold`  in  1  downstream stall; entry at queue head is not consumed while high
- `redirect`  in  1  one-cycle pulse: abandon current stream
- `redirect_pc`  in  32  new fetch address, sampled when `redirect`=1
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  fetch word address (bits [1:0] always 0)
- `imem_gnt`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  response data valid; in order, ≥1 cycle after grant
- `imem_rdata`  in  32  instruction word
- `pc_out`  out  32  PC of queue-head instruction
- `instr_out`  out  32  queue-head instruction
- `valid`  out  1  queue non-empty

## Operation
- State: `pc` (next fetch address), `outstanding` (0/1, at most one granted-but-unanswered fetch), `discard` (drop next response), 2-entry FIFO of {pc, instr} with `count` 0..2.
- Issue: `imem_req`=1 when not `redirect`, not `rst`, and `(outstanding==0 || imem_rvalid)` and `(2 - count) > outstanding`. `imem_addr` = `pc`. Request plus `imem_gnt` → `outstanding`<=1, `pc`<=`pc`+4 (wraps 0xFFFF_FFFC→0), fetch PC recorded for tag.
- `imem_addr` stable while `imem_req`=1 and `imem_gnt`=0, except across a redirect.
- Response: `imem_rvalid` with `discard`=0 → push {tag pc, `imem_rdata`}; with `discard`=1 → drop, clear `discard`. `outstanding` clears unless a new grant occurs same cycle.
- Pop: `valid` & ~`hold` → head removed at clock edge (same condition the fetch latch captures on). Push and pop same cycle legal at any `count`.
- Redirect: FIFO flushed (`count`<=0), `pc`<=`{redirect_pc[31:2],2'b00}`, `imem_req` forced 0 that cycle. If a fetch is in flight (outstanding and no `imem_rvalid` this cycle) → `discard`<=1. Redirect wins over simultaneous push/pop.
- Responses never pushed into a full FIFO (guaranteed by issue rule); a response arriving with `outstanding`=0 is a protocol error and is ignored.

## Timing
- Reset values: `pc`=`RESET_PC`, `count`=0, `outstanding`=0, `discard`=0; `valid`=0, `imem_req`=0 during reset; `pc_out`/`instr_out` = 0.
- First `imem_req` in the first cycle with `rst`=0, `imem_addr`=`RESET_PC`.
- Latency: grant at cycle N, `imem_rvalid` at N+k → `valid`=1 at N+k+1.
- Throughput: k=1 memory, `hold`=0 → one instruction per cycle sustained.
- Redirect at cycle R: `valid`=0 at R+1; new-address `imem_req` at R+1.
- Reset mid-fetch: all state cleared; responses after reset are ignored (`outstanding`=0).
- `pc_out`/`instr_out` driven from FIFO storage (no combinational path from `imem_rdata`).

## Configuration
- `FETCH_MISALIGN_TRAP_EN`: defined → adds output `fetch_fault` (1 bit, reset 0); redirect with `redirect_pc[1:0]`≠0 sets `fetch_fault`=1 and suppresses all `imem_req` until next aligned redirect (which clears it) or reset. Undefined → no port; `redirect_pc[1:0]` silently ignored.

## Test plan
- Reset release, k=1 memory returning addr as data, `hold`=0 → requests 0x0,0x4,0x8…; `valid`=1 from cycle 3 onward, one instr/cycle, `pc_out`=`instr_out`.
- `hold`=1 for 5 cycles with stream running → `count` reaches 2, `imem_req` drops, head stays 0x4/0x4; release → 0x4,0x8,0xC consumed with no gap or duplicate.
- `imem_gnt` withheld 3 cycles → `imem_addr` stable at 0x8 throughout; no PC advance.
- Redirect to 0x100 while fetch of 0x10 in flight (k=3) → 0x10 response dropped, `valid`=0 next cycle, next delivered `pc_out`=0x100.
- Redirect in same cycle as response and pop → FIFO empty next cycle, no discard set, next request 0x100.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x102 → `fetch_fault`=1, no requests; redirect to 0x200 → fault clears, fetch resumes at 0x200.
